fetch_unit: RTL

//   Instruction fetch stage placed directly upstream of datapath. Owns the program counter.

---
 rtl/fetch_unit.sv | 114 +++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues in-order word fetches under a credit limit,
// buffers returned words with their PCs and hands them to decode over valid/ready.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        RedirectValid,
  input  logic [31:0] RedirectPC,
  output logic [31:0] Instr,
  output logic [31:0] InstrPC,
  output logic        InstrValid,
  input  logic        InstrReady
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);

  logic [31:0]   fetchPc_q, fetchPc_d;
  logic [31:0]   rspPc_q, rspPc_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [PW-1:0] rdPtr_q, rdPtr_d;
  logic [PW-1:0] wrPtr_q, wrPtr_d;
  logic [31:0]   memPc_q   [FIFO_DEPTH];
  logic [31:0]   memData_q [FIFO_DEPTH];

  logic [CW:0] inUse;
  logic        accept;
  logic        pop;
  logic        push;
  logic        dropRsp;

  // Every accepted request already owns a FIFO slot, so responses can never stall.
  assign inUse          = {1'b0, count_q} + {1'b0, outstanding_q};
  assign imem_req_valid = reset && (inUse < DEPTH_W) && !RedirectValid;
  assign imem_addr      = fetchPc_q;
  assign accept         = imem_req_valid && imem_req_ready;

  assign InstrValid = (count_q != '0);
  assign Instr      = InstrValid ? memData_q[rdPtr_q] : 32'h0;
  assign InstrPC    = InstrValid ? memPc_q[rdPtr_q]   : 32'h0;
  assign pop        = InstrValid && InstrReady;

  assign dropRsp = imem_rsp_valid && (drop_q != '0);
  assign push    = imem_rsp_valid && (drop_q == '0) && !RedirectValid;

  always_comb begin
    fetchPc_d     = fetchPc_q;
    rspPc_d       = rspPc_q;
    count_d       = count_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    rdPtr_d       = rdPtr_q;
    wrPtr_d       = wrPtr_q;
    if (RedirectValid) begin
      // Everything still in flight after this cycle belongs to the old path.
      fetchPc_d     = {RedirectPC[31:2], 2'b00};
      rspPc_d       = {RedirectPC[31:2], 2'b00};
      count_d       = '0;
      rdPtr_d       = '0;
      wrPtr_d       = '0;
      outstanding_d = outstanding_q - CW'(imem_rsp_valid);
      drop_d        = outstanding_q - CW'(imem_rsp_valid);
    end else begin
      if (accept) fetchPc_d = fetchPc_q + 32'd4;
      if (push) begin
        rspPc_d = rspPc_q + 32'd4;
        wrPtr_d = wrPtr_q + 1'b1;
      end
      if (pop) rdPtr_d = rdPtr_q + 1'b1;
      if (dropRsp) drop_d = drop_q - 1'b1;
      count_d       = count_q + CW'(push) - CW'(pop);
      outstanding_d = outstanding_q + CW'(accept) - CW'(imem_rsp_valid);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetchPc_q     <= RESET_PC;
      rspPc_q       <= RESET_PC;
      count_q       <= '0;
      outstanding_q <= '0;
      drop_q        <= '0;
      rdPtr_q       <= '0;
      wrPtr_q       <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        memPc_q[i]   <= 32'h0;
        memData_q[i] <= 32'h0;
      end
    end else begin
      fetchPc_q     <= fetchPc_d;
      rspPc_q       <= rspPc_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      rdPtr_q       <= rdPtr_d;
      wrPtr_q       <= wrPtr_d;
      if (push) begin
        memPc_q[wrPtr_q]   <= rspPc_q;
        memData_q[wrPtr_q] <= imem_rsp_data;
      end
    end
  end

endmodule
